// File: rtl/gate_selftest_seq.sv
// Sweeps a 2-input gate under test through {a,b}=00,01,10,11, samples y after a settle window
// and compares it with EXPECT_TT. Defining GATE_SELFTEST_ABORT_EN adds an abort input.
module gate_selftest_seq #(
  parameter logic [3:0] EXPECT_TT  = 4'b1001,
  parameter int         SETTLE_CYC = 2,
  parameter int         PASSES     = 1,
  parameter int         ERR_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef GATE_SELFTEST_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       fail_vec,
  output logic             dut_a,
  output logic             dut_b,
  input  logic             dut_y
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [3:0]       fail_q, fail_d;
  logic [1:0]       vec_q, vec_d;
  logic [3:0]       pcnt_q, pcnt_d;
  logic [7:0]       scnt_q, scnt_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             abort_w;

`ifdef GATE_SELFTEST_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fail_q  <= '0;
      vec_q   <= '0;
      pcnt_q  <= '0;
      scnt_q  <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      vec_q   <= vec_d;
      pcnt_q  <= pcnt_d;
      scnt_q  <= scnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    fail_d  = fail_q;
    vec_d   = vec_q;
    pcnt_d  = pcnt_q;
    scnt_d  = scnt_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETTLE;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          err_d   = '0;
          fail_d  = '0;
          vec_d   = '0;
          pcnt_d  = '0;
          scnt_d  = '0;
          a_d     = 1'b0;
          b_d     = 1'b0;
        end
      end
      SETTLE: begin
        scnt_d = scnt_q + 8'd1;
        if (abort_w) begin
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = 1'b0;
          a_d     = 1'b0;
          b_d     = 1'b0;
        end else if (scnt_q == 8'(SETTLE_CYC - 1)) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (abort_w) begin
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = 1'b0;
          a_d     = 1'b0;
          b_d     = 1'b0;
        end else begin
          if (dut_y != EXPECT_TT[vec_q]) begin
            fail_d[vec_q] = 1'b1;
            if (err_q != {ERR_W{1'b1}}) err_d = err_q + 1'b1;
          end
          if (vec_q != 2'd3) begin
            state_d = SETTLE;
            vec_d   = vec_q + 2'd1;
            {a_d, b_d} = vec_q + 2'd1;
            scnt_d  = '0;
          end else if (pcnt_q < 4'(PASSES - 1)) begin
            state_d = SETTLE;
            pcnt_d  = pcnt_q + 4'd1;
            vec_d   = '0;
            a_d     = 1'b0;
            b_d     = 1'b0;
            scnt_d  = '0;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
            a_d     = 1'b0;
            b_d     = 1'b0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_q;
  assign fail_vec = fail_q;
  assign dut_a    = a_q;
  assign dut_b    = b_q;

endmodule

// File: tb/tb_gate_selftest_seq.sv
// Randomized bench for gate_selftest_seq: two configurations, a truth-table GUT model and
// timing/result expectations derived from the sweep arithmetic.
module tb_gate_selftest_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] start_v = 2'b00;
  logic [1:0] abort_v = 2'b00;
  logic [1:0] y_v = 2'b00;
  logic [1:0] busy_v, done_v, pass_v, a_v, b_v;
  logic [3:0] err0;
  logic [1:0] err1;
  logic [3:0] fail0, fail1;

  int n_checks = 0;
  int n_fail   = 0;

  int         S_c  [2] = '{2, 1};
  int         P_c  [2] = '{1, 3};
  int         W_c  [2] = '{4, 2};
  logic [3:0] ETT_c[2] = '{4'b1001, 4'b0110};

  always #5 clk = ~clk;

  gate_selftest_seq u0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]),
`ifdef GATE_SELFTEST_ABORT_EN
    .abort(abort_v[0]),
`endif
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_cnt(err0),
    .fail_vec(fail0), .dut_a(a_v[0]), .dut_b(b_v[0]), .dut_y(y_v[0])
  );

  gate_selftest_seq #(.EXPECT_TT(4'b0110), .SETTLE_CYC(1), .PASSES(3), .ERR_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]),
`ifdef GATE_SELFTEST_ABORT_EN
    .abort(abort_v[1]),
`endif
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_cnt(err1),
    .fail_vec(fail1), .dut_a(a_v[1]), .dut_b(b_v[1]), .dut_y(y_v[1])
  );

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int popc(input logic [3:0] x);
    return int'(x[0]) + int'(x[1]) + int'(x[2]) + int'(x[3]);
  endfunction

  function automatic int unsigned err_of(input int i);
    return (i == 0) ? int'(err0) : int'({2'b00, err1});
  endfunction

  function automatic int unsigned fail_of(input int i);
    return (i == 0) ? int'(fail0) : int'(fail1);
  endfunction

  // One full run on instance i with the GUT behaving as truth table gut. Called #1 after a
  // posedge with the instance idle; edge 1 is the start edge. stray pulses start while busy;
  // hold keeps start high through DONE so the next call begins on the first IDLE cycle.
  task automatic run_one(input int i, input logic [3:0] gut, input bit stray, input bit hold);
    int S, P, L, mism, mx, exp_err;
    logic [3:0] diff;
    S = S_c[i];
    P = P_c[i];
    L = P * 4 * (S + 1) + 1;
    diff = gut ^ ETT_c[i];
    mism = P * popc(diff);
    mx = (1 << W_c[i]) - 1;
    exp_err = (mism > mx) ? mx : mism;
    start_v[i] = 1'b1;
    for (int n = 1; n <= L + 1; n++) begin
      @(posedge clk);
      #1;
      if (n < L) begin
        int t, v;
        t = n - 1;
        v = (t / (S + 1)) % 4;
        check("vec", {a_v[i], b_v[i]}, v);
        if (done_v[i] || !busy_v[i]) check("busy_nodone", {busy_v[i], done_v[i]}, 2'b10);
        y_v[i] = ((t % (S + 1)) == S) ? gut[v] : 1'($urandom);
        start_v[i] = hold | (stray & 1'($urandom));
      end else if (n == L) begin
        check("done", done_v[i], 1);
        check("busy_in_done", busy_v[i], 1);
        check("vec_done", {a_v[i], b_v[i]}, 0);
        check("err_cnt", err_of(i), exp_err);
        check("fail_vec", fail_of(i), diff);
        check("pass", pass_v[i], (mism == 0) ? 1 : 0);
        start_v[i] = hold | (stray & 1'($urandom));
      end else begin
        check("done_pulse", done_v[i], 0);
        check("busy_after", busy_v[i], 0);
        check("pass_hold", pass_v[i], (mism == 0) ? 1 : 0);
        start_v[i] = hold;
      end
    end
  endtask

  initial begin
    logic [3:0] g;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_busy", busy_v[i], 0);
      check("rst_done", done_v[i], 0);
      check("rst_pass", pass_v[i], 0);
      check("rst_err", err_of(i), 0);
      check("rst_fail", fail_of(i), 0);
      check("rst_ab", {a_v[i], b_v[i]}, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases: XNOR pass, XOR all-fail, stuck-at-1, back-to-back restart.
    run_one(0, 4'b1001, 1'b0, 1'b0);
    run_one(0, 4'b0110, 1'b1, 1'b0);
    run_one(0, 4'b1111, 1'b0, 1'b1);
    run_one(0, 4'b1001, 1'b1, 1'b0);
    run_one(1, 4'b0110, 1'b0, 1'b0);
    run_one(1, 4'b1001, 1'b1, 1'b0);
    run_one(1, 4'b1111, 1'b0, 1'b0);

    for (int k = 0; k < 8; k++) begin
      g = 4'($urandom);
      run_one(k % 2, g, 1'($urandom), (k < 7) && ((k % 2) == 1) ? 1'($urandom) : 1'b0);
      start_v = 2'b00;
    end
    start_v = 2'b00;
    @(posedge clk);
    #1;

    // Reset during the third vector of an XOR run.
    start_v[0] = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      int t, v;
      @(posedge clk);
      #1;
      t = n - 1;
      v = (t / 3) % 4;
      start_v[0] = 1'b0;
      y_v[0] = ((t % 3) == 2) ? g[0] ^ 1'b1 ^ 1'b1 ^ ETT_c[0][v] ^ 1'b1 ^ g[0] : 1'($urandom);
    end
    check("pre_rst_err", err0, 2);
    check("pre_rst_vec", {a_v[0], b_v[0]}, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy_v[0], 0);
    check("arst_err", err0, 0);
    check("arst_fail", fail0, 0);
    check("arst_ab", {a_v[0], b_v[0]}, 0);
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1;
      check("arst_nodone", done_v[0], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_one(0, 4'b1001, 1'b0, 1'b0);

`ifdef GATE_SELFTEST_ABORT_EN
    // Abort sampled at edge 5 while SETTLE-ing vector 1 of an XOR run.
    start_v[0] = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      int t, v;
      @(posedge clk);
      #1;
      t = n - 1;
      v = (t / 3) % 4;
      start_v[0] = 1'b0;
      y_v[0] = ((t % 3) == 2) ? ~ETT_c[0][v] : 1'($urandom);
    end
    abort_v[0] = 1'b1;
    @(posedge clk);
    #1;
    abort_v[0] = 1'b0;
    check("abort_done", done_v[0], 1);
    check("abort_pass", pass_v[0], 0);
    check("abort_err", err0, 1);
    check("abort_fail", fail0, 1);
    check("abort_ab", {a_v[0], b_v[0]}, 0);
    @(posedge clk);
    #1;
    check("abort_idle", {busy_v[0], done_v[0]}, 0);
    run_one(0, 4'b1001, 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
